// File: rtl/pll_reset_sequencer_if.sv
// Signal bundle between the PLL reset sequencer and the PLL wrapper / system reset consumers.
// The master modport is the sequencer side.
interface pll_reset_sequencer_if;
    logic       i_locked;
    logic       o_pll_resetb;
    logic       o_sys_reset;
    logic       o_ready;
    logic       o_fault;
    logic [1:0] o_retry_count;
    logic [7:0] o_relock_count;

    modport master (
        input  i_locked,
        output o_pll_resetb,
        output o_sys_reset,
        output o_ready,
        output o_fault,
        output o_retry_count,
        output o_relock_count
    );

    modport slave (
        output i_locked,
        input  o_pll_resetb,
        input  o_sys_reset,
        input  o_ready,
        input  o_fault,
        input  o_retry_count,
        input  o_relock_count
    );
endinterface

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: runs on the reference clock, restarts the PLL until lock is stable,
// then releases the system reset. After repeated lock timeouts it latches a fault.
module pll_reset_sequencer #(
    parameter int unsigned RESET_PULSE  = 16,
    parameter int unsigned LOCK_TIMEOUT = 65536,
    parameter int unsigned LOCK_STABLE  = 1024,
    parameter int unsigned HOLD_CYCLES  = 256,
    parameter int unsigned MAX_RETRIES  = 3
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    pll_reset_sequencer_if.master pll_if
);

    function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_COUNT = max_of(max_of(RESET_PULSE, LOCK_TIMEOUT),
                                               max_of(LOCK_STABLE, HOLD_CYCLES));
    localparam int unsigned CW = (MAX_COUNT > 32'd1) ? $clog2(MAX_COUNT) : 1;

    typedef enum logic [2:0] {
        ST_PLL_RESET = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILISE = 3'd2,
        ST_HOLD      = 3'd3,
        ST_RUN       = 3'd4,
        ST_FAULT     = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [CW-1:0]   r_counter;
    logic [CW-1:0]   w_next_counter;
    logic            r_sync1;
    logic            r_sync2;
    logic            w_lock_s;
    logic [1:0]      r_retry_count;
    logic [1:0]      w_next_retry;
    logic [7:0]      r_relock_count;
    logic [7:0]      w_next_relock;
    logic [7:0]      w_relock_inc;
    logic            r_pll_resetb;
    logic            r_sys_reset;
    logic            r_ready;
    logic            r_fault;

    assign w_lock_s     = r_sync2;
    assign w_relock_inc = (r_relock_count == 8'hFF) ? 8'hFF : (r_relock_count + 8'd1);

    // Two-flop synchroniser for the asynchronous PLL lock output.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_if.i_locked;
            r_sync2 <= r_sync1;
        end
    end

    // Next-state, counter and status-counter logic.
    always_comb begin
        w_next_state  = r_state;
        w_next_retry  = r_retry_count;
        w_next_relock = r_relock_count;
        case (r_state)
            ST_PLL_RESET: begin
                if (r_counter == CW'(RESET_PULSE - 32'd1)) begin
                    w_next_state = ST_WAIT_LOCK;
                end else begin
                    w_next_state = ST_PLL_RESET;
                end
            end
            ST_WAIT_LOCK: begin
                // A lock seen in the timeout cycle still counts as a lock.
                if (w_lock_s) begin
                    w_next_state = ST_STABILISE;
                end else if (r_counter == CW'(LOCK_TIMEOUT - 32'd1)) begin
                    if (r_retry_count == 2'(MAX_RETRIES)) begin
                        w_next_state = ST_FAULT;
                    end else begin
                        w_next_state = ST_PLL_RESET;
                        w_next_retry = r_retry_count + 2'd1;
                    end
                end else begin
                    w_next_state = ST_WAIT_LOCK;
                end
            end
            ST_STABILISE: begin
                if (!w_lock_s) begin
                    w_next_state = ST_WAIT_LOCK;
                end else if (r_counter == CW'(LOCK_STABLE - 32'd1)) begin
                    w_next_state = ST_HOLD;
                end else begin
                    w_next_state = ST_STABILISE;
                end
            end
            ST_HOLD: begin
                if (!w_lock_s) begin
                    w_next_state  = ST_PLL_RESET;
                    w_next_relock = w_relock_inc;
                end else if (r_counter == CW'(HOLD_CYCLES - 32'd1)) begin
                    w_next_state = ST_RUN;
                    w_next_retry = 2'd0;
                end else begin
                    w_next_state = ST_HOLD;
                end
            end
            ST_RUN: begin
                if (!w_lock_s) begin
                    w_next_state  = ST_PLL_RESET;
                    w_next_relock = w_relock_inc;
                end else begin
                    w_next_state = ST_RUN;
                end
            end
            ST_FAULT: begin
                w_next_state = ST_FAULT;
            end
            default: begin
                w_next_state = ST_PLL_RESET;
            end
        endcase

        // RUN and FAULT have no timed exit, so the counter simply parks there.
        if (w_next_state != r_state) begin
            w_next_counter = '0;
        end else if ((r_state == ST_RUN) || (r_state == ST_FAULT)) begin
            w_next_counter = r_counter;
        end else begin
            w_next_counter = r_counter + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // State, counter and registered outputs, all decoded from the next state.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state        <= ST_PLL_RESET;
            r_counter      <= '0;
            r_retry_count  <= 2'd0;
            r_relock_count <= 8'd0;
            r_pll_resetb   <= 1'b0;
            r_sys_reset    <= 1'b1;
            r_ready        <= 1'b0;
            r_fault        <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_counter      <= w_next_counter;
            r_retry_count  <= w_next_retry;
            r_relock_count <= w_next_relock;
            r_pll_resetb   <= (w_next_state != ST_PLL_RESET) && (w_next_state != ST_FAULT);
            r_sys_reset    <= (w_next_state != ST_RUN);
            r_ready        <= (w_next_state == ST_RUN);
            r_fault        <= (w_next_state == ST_FAULT);
        end
    end

    assign pll_if.o_pll_resetb   = r_pll_resetb;
    assign pll_if.o_sys_reset    = r_sys_reset;
    assign pll_if.o_ready        = r_ready;
    assign pll_if.o_fault        = r_fault;
    assign pll_if.o_retry_count  = r_retry_count;
    assign pll_if.o_relock_count = r_relock_count;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench for pll_reset_sequencer: directed scenarios plus randomised lock
// activity, all compared every cycle against a phase/elapsed-time reference model.
module tb_pll_reset_sequencer;

    localparam int RP = 4;
    localparam int LT = 20;
    localparam int LS = 8;
    localparam int HC = 4;
    localparam int MR = 2;

    localparam int PH_RST   = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_STAB  = 2;
    localparam int PH_HOLD  = 3;
    localparam int PH_RUN   = 4;
    localparam int PH_FAULT = 5;

    logic clk = 1'b0;
    logic rst;

    pll_reset_sequencer_if u_if();

    pll_reset_sequencer #(
        .RESET_PULSE (RP),
        .LOCK_TIMEOUT(LT),
        .LOCK_STABLE (LS),
        .HOLD_CYCLES (HC),
        .MAX_RETRIES (MR)
    ) u_dut (
        .i_clock(clk),
        .i_reset(rst),
        .pll_if (u_if)
    );

    always #5 clk = ~clk;

    int n_compared   = 0;
    int n_mismatched = 0;

    // Reference model: which phase we are in, how long we have been there, and the counters.
    int m_phase;
    int m_t;
    int m_retry;
    int m_relock;
    bit m_lock_hist[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: observed %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void m_enter(input int ph);
        m_phase = ph;
        m_t     = 0;
    endfunction

    function automatic void model_step(input bit r, input bit lk);
        bit ls;
        // The design reacts to locked as it was two edges earlier.
        ls = m_lock_hist[0];
        if (r) begin
            m_enter(PH_RST);
            m_retry    = 0;
            m_relock   = 0;
            m_lock_hist = '{1'b0, 1'b0};
            return;
        end
        void'(m_lock_hist.pop_front());
        m_lock_hist.push_back(lk);
        m_t++;
        if (m_phase == PH_RST) begin
            if (m_t == RP) m_enter(PH_WAIT);
        end else if (m_phase == PH_WAIT) begin
            if (ls) m_enter(PH_STAB);
            else if (m_t == LT) begin
                if (m_retry == MR) m_enter(PH_FAULT);
                else begin
                    m_retry++;
                    m_enter(PH_RST);
                end
            end
        end else if (m_phase == PH_STAB) begin
            if (!ls) m_enter(PH_WAIT);
            else if (m_t == LS) m_enter(PH_HOLD);
        end else if (m_phase == PH_HOLD || m_phase == PH_RUN) begin
            if (!ls) begin
                if (m_relock < 255) m_relock++;
                m_enter(PH_RST);
            end else if (m_phase == PH_HOLD && m_t == HC) begin
                m_retry = 0;
                m_enter(PH_RUN);
            end
        end
    endfunction

    task automatic compare_all();
        check_val("pll_resetb", u_if.o_pll_resetb, (m_phase != PH_RST && m_phase != PH_FAULT) ? 1 : 0);
        check_val("sys_reset", u_if.o_sys_reset, (m_phase != PH_RUN) ? 1 : 0);
        check_val("ready", u_if.o_ready, (m_phase == PH_RUN) ? 1 : 0);
        check_val("fault", u_if.o_fault, (m_phase == PH_FAULT) ? 1 : 0);
        check_val("retry_count", u_if.o_retry_count, m_retry);
        check_val("relock_count", u_if.o_relock_count, m_relock);
    endtask

    // One clock: drive inputs after the falling edge, step the model at the rising edge,
    // compare on the next falling edge.
    task automatic tick(input bit r, input bit lk);
        rst = r;
        u_if.i_locked = lk;
        @(posedge clk);
        model_step(r, lk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_resetb"}, u_if.o_pll_resetb, 0);
        check_val({tag, "_sysrst"}, u_if.o_sys_reset, 1);
        check_val({tag, "_ready"}, u_if.o_ready, 0);
        check_val({tag, "_fault"}, u_if.o_fault, 0);
        check_val({tag, "_retry"}, u_if.o_retry_count, 0);
        check_val({tag, "_relock"}, u_if.o_relock_count, 0);
    endtask

    initial begin
        int len;
        bit lv;
        rst = 1'b1;
        u_if.i_locked = 1'b1;
        m_lock_hist = '{1'b0, 1'b0};
        @(negedge clk);

        // Nominal lock: sys_reset falls exactly at edge RP+1+LS+HC = 17.
        repeat (3) tick(1'b1, 1'b1);
        check_reset_values("por");
        for (int k = 1; k <= 17; k++) begin
            tick(1'b0, 1'b1);
            if (k == RP) check_val("nom_resetb_high", u_if.o_pll_resetb, 1);
            if (k == 16) check_val("nom_sysrst_e16", u_if.o_sys_reset, 1);
            if (k == 17) check_val("nom_sysrst_e17", u_if.o_sys_reset, 0);
            if (k == 17) check_val("nom_ready_e17", u_if.o_ready, 1);
        end
        repeat (5) tick(1'b0, 1'b1);

        // Lock loss in RUN: sys_reset back up within 3 edges, then recovery.
        for (int k = 1; k <= 3; k++) tick(1'b0, 1'b0);
        check_val("loss_sysrst_3e", u_if.o_sys_reset, 1);
        check_val("loss_ready_3e", u_if.o_ready, 0);
        repeat (25) tick(1'b0, 1'b1);
        check_val("loss_relock", u_if.o_relock_count, 1);
        check_val("loss_recovered", u_if.o_ready, 1);

        // Lock chatter midway through STABILISE.
        tick(1'b1, 1'b1);
        repeat (RP + 1 + 4) tick(1'b0, 1'b1);
        repeat (3) tick(1'b0, 1'b0);
        repeat (8) tick(1'b0, 1'b1);
        check_val("chatter_sysrst", u_if.o_sys_reset, 1);
        repeat (20) tick(1'b0, 1'b1);
        check_val("chatter_ready", u_if.o_ready, 1);
        check_val("chatter_relock", u_if.o_relock_count, 0);

        // Timeout to FAULT, then locked returning is ignored.
        tick(1'b1, 1'b0);
        repeat (3 * (RP + LT) + 10) tick(1'b0, 1'b0);
        check_val("to_fault", u_if.o_fault, 1);
        repeat (20) tick(1'b0, 1'b1);
        check_val("to_fault_sticky", u_if.o_fault, 1);
        check_val("to_fault_resetb", u_if.o_pll_resetb, 0);

        // Reset in FAULT, then reset during HOLD.
        tick(1'b1, 1'b1);
        check_reset_values("rst_fault");
        repeat (RP + 1 + LS + 2) tick(1'b0, 1'b1);
        tick(1'b1, 1'b1);
        check_reset_values("rst_hold");
        repeat (30) tick(1'b0, 1'b1);
        check_val("rst_restart_ready", u_if.o_ready, 1);

        // Randomised lock activity with occasional resets.
        repeat (150) begin
            len = $urandom_range(1, 40);
            lv  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) tick(1'b1, lv);
            for (int i = 0; i < len; i++) tick(1'b0, lv);
        end

        // Relock saturation: 260 losses from RUN.
        tick(1'b1, 1'b1);
        repeat (25) tick(1'b0, 1'b1);
        for (int n = 0; n < 260; n++) begin
            repeat (3) tick(1'b0, 1'b0);
            repeat (22) tick(1'b0, 1'b1);
        end
        check_val("sat_relock", u_if.o_relock_count, 255);
        check_val("sat_ready", u_if.o_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
